// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: requester-side bus of the shared BCD converter arbiter
interface bcd_conv_arbiter_if;
  logic [1:0] req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [1:0] ack;
  logic busy;
  logic owner;
  logic [15:0] result;
  logic cy_out;
  logic ovf;
  modport master (
    output req, data0, data1,
    input ack, busy, owner, result, cy_out, ovf
  );
  modport slave (
    input req, data0, data1,
    output ack, busy, owner, result, cy_out, ovf
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin owner of the shared multicycle binary-to-BCD converter
// Define BCD_SAT_EN to saturate operands above 9999 to 0x9999 and flag ovf.
module bcd_conv_arbiter #(
  parameter int SETTLE_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  bcd_conv_arbiter_if.slave bus,
  output logic [15:0] bin_out,
  input logic [15:0] bcd_in,
  input logic cy_in
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t st, nxt;
  logic [3:0] cnt;
  logic last, owner, win, grant, capture, cy_out;
  logic [1:0] ack;
  logic [15:0] result, res_n;
  always_comb begin
    win = &bus.req ? ~last : bus.req[1];
    grant = st == IDLE && |bus.req;
    capture = st == SETTLE && cnt == 4'd0;
    nxt = grant ? SETTLE : capture ? DONE : st == DONE ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  // bin_out only moves on a grant, so the converter input is frozen through SETTLE and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out <= 16'h0000;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= 4'd0;
      ack <= 2'b00;
      result <= 16'h0000;
      cy_out <= 1'b0;
    end else begin
      ack <= capture ? (owner ? 2'b10 : 2'b01) : 2'b00;
      if (grant) begin
        bin_out <= win ? bus.data1 : bus.data0;
        owner <= win;
        last <= win;
        cnt <= 4'(SETTLE_CYC - 1);
      end else if (st == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (capture) begin
        result <= res_n;
        cy_out <= cy_in;
      end
    end
  end
`ifdef BCD_SAT_EN
  logic sat, ovf;
  assign sat = bin_out > 16'd9999;
  assign res_n = sat ? 16'h9999 : bcd_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (capture) ovf <= sat;
  assign bus.ovf = ovf;
`else
  assign res_n = bcd_in;
  assign bus.ovf = 1'b0;
`endif
  assign bus.ack = ack;
  assign bus.busy = st != IDLE;
  assign bus.owner = owner;
  assign bus.result = result;
  assign bus.cy_out = cy_out;
endmodule
